// File: rtl/grey_pkg.sv
// grey_pkg -- shared constants, state encoding and Gray helper for grey_scan.
//   NUM_DIGITS : digits per frame (12)
//   DIGIT_W    : width of one Gray-coded digit (5)
//   state_t    : scan FSM states
//   GLYPH_*    : 7-segment patterns, bit order gfedcba, active high
package grey_pkg;

   localparam int NUM_DIGITS = 12;
   localparam int DIGIT_W    = 5;
   localparam int IDX_W      = 4;

   typedef enum logic [1:0] {IDLE, LOAD, SHOW, BLANK} state_t;

   localparam logic [6:0] GLYPH_0   = 7'b0111111;
   localparam logic [6:0] GLYPH_1   = 7'b0000110;
   localparam logic [6:0] GLYPH_2   = 7'b1011011;
   localparam logic [6:0] GLYPH_3   = 7'b1001111;
   localparam logic [6:0] GLYPH_4   = 7'b1100110;
   localparam logic [6:0] GLYPH_5   = 7'b1101101;
   localparam logic [6:0] GLYPH_6   = 7'b1111101;
   localparam logic [6:0] GLYPH_7   = 7'b0000111;
   localparam logic [6:0] GLYPH_8   = 7'b1111111;
   localparam logic [6:0] GLYPH_9   = 7'b1101111;
   localparam logic [6:0] GLYPH_ERR = 7'b1000000;

   // Reflected Gray to binary: MSB passes through, each lower bit folds in
   // the binary bit above it.
   function automatic logic [DIGIT_W-1:0] gray2bin(input logic [DIGIT_W-1:0] g);
      logic [DIGIT_W-1:0] b;
      b[DIGIT_W-1] = g[DIGIT_W-1];
      for (int i = DIGIT_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

endpackage

// File: rtl/grey_digit_decode.sv
// grey_digit_decode -- combinational Gray digit to 7-segment glyph.
//   gray : 5-bit reflected Gray code digit
//   seg  : glyph gfedcba; values 10..31 show the error glyph (segment g)
module grey_digit_decode
   import grey_pkg::*;
(
   input  logic [DIGIT_W-1:0] gray,
   output logic [6:0]         seg
);

   logic [DIGIT_W-1:0] bin;

   always_comb begin
      bin = gray2bin(gray);
      case (bin)
         5'd0:    seg = GLYPH_0;
         5'd1:    seg = GLYPH_1;
         5'd2:    seg = GLYPH_2;
         5'd3:    seg = GLYPH_3;
         5'd4:    seg = GLYPH_4;
         5'd5:    seg = GLYPH_5;
         5'd6:    seg = GLYPH_6;
         5'd7:    seg = GLYPH_7;
         5'd8:    seg = GLYPH_8;
         5'd9:    seg = GLYPH_9;
         default: seg = GLYPH_ERR;
      endcase
   end

endmodule

// File: rtl/grey_scan.sv
// grey_scan -- multiplexed scanner for twelve Gray-coded decimal digits.
// Each frame: LOAD (snapshot digits), then for idx 11..0 SHOW for DWELL
// cycles followed by one BLANK cycle. Frame = 1 + 12*(DWELL+1) cycles.
//   clk, reset  : clock, asynchronous active-high reset
//   digits      : 12 x 5-bit Gray digits, [4:0] = ones
//   scan_en     : start enable, sampled in IDLE and the final BLANK only
//   seg         : glyph gfedcba of the digit shown
//   digit_idx   : index of the digit shown (11 = MSD)
//   valid       : high while seg/digit_idx carry a digit
//   frame_start : pulse on the first SHOW cycle of a frame
//   io_out      : {frame_start, seg}
// Optional: GREY_SCAN_LZB_EN enables leading-zero blanking.
module grey_scan
   import grey_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
   input  logic                          scan_en,
   output logic [6:0]                    seg,
   output logic [IDX_W-1:0]              digit_idx,
   output logic                          valid,
   output logic                          frame_start,
   output logic [7:0]                    io_out
);

   localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

   state_t state, state_n;
   logic   armed;   // holds the FSM in IDLE for one edge after reset release
   logic [NUM_DIGITS-1:0][DIGIT_W-1:0] shadow;
   logic [IDX_W-1:0] idx, idx_n;
   logic [7:0]       cnt, cnt_n;
   logic [6:0]       glyph, seg_n;
   logic             valid_n;

   always_comb begin
      state_n = state;
      idx_n   = idx;
      cnt_n   = cnt;
      case (state)
         IDLE:  if (armed && scan_en) state_n = LOAD;
         LOAD:  begin
            state_n = SHOW;
            cnt_n   = '0;
         end
         SHOW:  if (cnt == CNT_LAST) begin
            state_n = BLANK;
            cnt_n   = '0;
         end else begin
            cnt_n = cnt + 8'd1;
         end
         BLANK: if (idx != '0) begin
            idx_n   = idx - 1'b1;
            state_n = SHOW;
         end else if (scan_en) begin
            state_n = LOAD;
         end else begin
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (state_n == LOAD) idx_n = IDX_W'(NUM_DIGITS - 1);
   end

   // Outputs are registered from next-state values so they line up with
   // the state they describe. The snapshot is taken on entry to LOAD, so
   // the shadow already holds the frame when the first SHOW is decoded.
   grey_digit_decode u_dec (
      .gray (shadow[idx_n]),
      .seg  (glyph)
   );

   assign valid_n = (state_n == SHOW);

`ifdef GREY_SCAN_LZB_EN
   logic lead, blank_n;

   // lead stays set while every digit from the MSD down to i is zero;
   // the ones digit is never considered for blanking.
   always_comb begin
      lead    = 1'b1;
      blank_n = 1'b0;
      for (int i = NUM_DIGITS-1; i >= 1; i--) begin
         lead = lead && (shadow[i] == '0);
         if (idx_n == IDX_W'(i)) blank_n = lead;
      end
      seg_n = (valid_n && !blank_n) ? glyph : 7'd0;
   end
`else
   always_comb seg_n = valid_n ? glyph : 7'd0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         armed       <= 1'b0;
         idx         <= '0;
         cnt         <= '0;
         shadow      <= '0;
         seg         <= '0;
         valid       <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         armed       <= 1'b1;
         state       <= state_n;
         idx         <= idx_n;
         cnt         <= cnt_n;
         if (state_n == LOAD) shadow <= digits;
         seg         <= seg_n;
         valid       <= valid_n;
         frame_start <= (state == LOAD);
      end
   end

   assign digit_idx = idx;
   assign io_out    = {frame_start, seg};

endmodule
